// File: rtl/mips_program_loader_if.sv
// Byte-stream, program-memory write and status signals of the program loader.
// The loader takes the slave modport; the boot source/bench takes the master modport.
interface mips_program_loader_if;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        error_o;
    logic [15:0] words_loaded_o;

    modport slave (
        input  start_i,
        input  byte_valid_i,
        input  byte_data_i,
        output byte_ready_o,
        output mem_write_o,
        output mem_address_o,
        output mem_data_o,
        output cpu_hold_o,
        output done_o,
        output error_o,
        output words_loaded_o
    );

    modport master (
        output start_i,
        output byte_valid_i,
        output byte_data_i,
        input  byte_ready_o,
        input  mem_write_o,
        input  mem_address_o,
        input  mem_data_o,
        input  cpu_hold_o,
        input  done_o,
        input  error_o,
        input  words_loaded_o
    );
endinterface

// File: rtl/mips_program_loader.sv
// Boot loader: assembles big-endian words from a byte stream, writes them to program memory
// from word 0, verifies an XOR checksum and holds the CPU in reset until a good load completes.
module mips_program_loader #(
    parameter int unsigned MEMORY_DEPTH = 256
) (
    input logic                   clk,
    input logic                   reset,
    mips_program_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] word_q, word_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [31:0] len_q, len_d;
    logic [31:0] csum_q, csum_d;
    logic        ready_q, ready_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        accept;
    logic        last_byte;
    logic [31:0] word_full;
    logic [15:0] word_cnt_inc;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        word_cnt_d   = word_cnt_q;
        len_d        = len_q;
        csum_d       = csum_q;
        ready_d      = ready_q;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        hold_d       = hold_q;
        done_d       = done_q;
        error_d      = error_q;

        accept       = bus.byte_valid_i & ready_q;
        last_byte    = accept & (byte_cnt_q == 2'd3);
        // Earlier bytes sit in word_q, so byte 0 ends up in [31:24].
        word_full    = {word_q, bus.byte_data_i};
        word_cnt_inc = word_cnt_q + 16'd1;

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_d     = {word_q[15:0], bus.byte_data_i};
        end

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (bus.start_i) begin
                    state_d    = StLen;
                    byte_cnt_d = 2'd0;
                    word_d     = 24'd0;
                    word_cnt_d = 16'd0;
                    csum_d     = 32'd0;
                    ready_d    = 1'b1;
                    hold_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end
            end
            StLen: begin
                if (last_byte) begin
                    len_d = word_full;
                    if (word_full == 32'd0 || word_full > 32'(MEMORY_DEPTH)) begin
                        state_d = StError;
                        ready_d = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (last_byte) begin
                    mem_data_d  = word_full;
                    mem_addr_d  = {16'd0, word_cnt_q[13:0], 2'b00};
                    mem_write_d = 1'b1;
                    csum_d      = csum_q ^ word_full;
                    word_cnt_d  = word_cnt_inc;
                    if ({16'd0, word_cnt_inc} == len_q) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (last_byte) begin
                    ready_d = 1'b0;
                    if (word_full == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StError;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            byte_cnt_q  <= 2'd0;
            word_q      <= 24'd0;
            word_cnt_q  <= 16'd0;
            len_q       <= 32'd0;
            csum_q      <= 32'd0;
            ready_q     <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_data_q  <= 32'd0;
            hold_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            ready_q     <= ready_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.byte_ready_o   = ready_q;
    assign bus.mem_write_o    = mem_write_q;
    assign bus.mem_address_o  = mem_addr_q;
    assign bus.mem_data_o     = mem_data_q;
    assign bus.cpu_hold_o     = hold_q;
    assign bus.done_o         = done_q;
    assign bus.error_o        = error_q;
    assign bus.words_loaded_o = word_cnt_q;

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed bench for mips_program_loader: table of load sessions plus reset and abort sequences.
module tb_mips_program_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;

    mips_program_loader_if bus ();

    mips_program_loader #(
        .MEMORY_DEPTH(256)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] len;
        logic [31:0] csum;
        int          period;
        bit          send_check;
        bit          exp_done;
        bit          exp_error;
        int          exp_words;
        int          exp_writes;
    } vec_t;

    logic [31:0] prog [3];
    vec_t        vecs [5];
    int          checks = 0;
    int          failures = 0;
    int          total_writes = 0;
    bit          prev_wr = 1'b0;
    bit          dbl_strobe = 1'b0;

    // Write strobes are counted and must never last two cycles.
    always @(negedge clk) begin
        if (bus.mem_write_o) begin
            total_writes <= total_writes + 1;
            if (prev_wr) dbl_strobe <= 1'b1;
        end
        prev_wr <= bus.mem_write_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Called and returns at a negedge; waits for ready with a bounded budget.
    task automatic send_byte(input logic [7:0] b, input int period, input bit strict);
        int waited = 0;
        bus.byte_valid_i = 1'b0;
        repeat (period - 1) @(negedge clk);
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = b;
        if (strict) check("ready_sustained", 32'(bus.byte_ready_o), 32'd1);
        while (!bus.byte_ready_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.byte_ready_o) begin
            check("ready_timeout", 32'(bus.byte_ready_o), 32'd1);
        end else begin
            @(negedge clk);
        end
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int period, input bit strict,
                             input bit is_data, input int idx);
        logic [31:0] tmp;
        tmp = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(tmp[31:24], period, strict);
            tmp = tmp << 8;
        end
        if (is_data) begin
            check("write_strobe", 32'(bus.mem_write_o), 32'd1);
            check("write_addr", bus.mem_address_o, 32'(idx * 4));
            check("write_data", bus.mem_data_o, w);
        end
    endtask

    task automatic run_nominal(input int period, input bit strict);
        pulse_start();
        send_word(32'd3, period, strict, 1'b0, 0);
        for (int k = 0; k < 3; k++) send_word(prog[k], period, strict, 1'b1, k);
        send_word(32'h0008_5026, period, strict, 1'b0, 0);
    endtask

    initial begin
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h2109_0003;
        prog[2] = 32'h0109_5020;
        vecs[0] = '{"nominal",   32'd3,   32'h0008_5026, 1, 1'b1, 1'b1, 1'b0, 3, 3};
        vecs[1] = '{"bad_csum",  32'd3,   32'h0008_5027, 1, 1'b1, 1'b0, 1'b1, 3, 3};
        vecs[2] = '{"len_zero",  32'd0,   32'h0,         1, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[3] = '{"len_257",   32'd257, 32'h0,         1, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[4] = '{"throttled", 32'd3,   32'h0008_5026, 3, 1'b1, 1'b1, 1'b0, 3, 3};

        bus.start_i      = 1'b0;
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = 8'hA5;

        // Reset held 3 cycles with a byte offered.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.byte_ready_o), 32'd0);
        check("rst_write", 32'(bus.mem_write_o), 32'd0);
        check("rst_addr", bus.mem_address_o, 32'd0);
        check("rst_data", bus.mem_data_o, 32'd0);
        check("rst_hold", 32'(bus.cpu_hold_o), 32'd1);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_error", 32'(bus.error_o), 32'd0);
        check("rst_words", 32'(bus.words_loaded_o), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", 32'(bus.byte_ready_o), 32'd0);
        bus.byte_valid_i = 1'b0;

        for (int i = 0; i < 5; i++) begin
            int base;
            base = total_writes;
            pulse_start();
            send_word(vecs[i].len, vecs[i].period, vecs[i].period == 1, 1'b0, 0);
            for (int k = 0; k < vecs[i].exp_writes; k++)
                send_word(prog[k], vecs[i].period, vecs[i].period == 1, 1'b1, k);
            if (vecs[i].send_check)
                send_word(vecs[i].csum, vecs[i].period, vecs[i].period == 1, 1'b0, 0);
            check({vecs[i].name, "_done"}, 32'(bus.done_o), 32'(vecs[i].exp_done));
            check({vecs[i].name, "_error"}, 32'(bus.error_o), 32'(vecs[i].exp_error));
            bus.byte_valid_i = 1'b1;
            bus.byte_data_i  = 8'h5A;
            repeat (2) @(negedge clk);
            check({vecs[i].name, "_ready_end"}, 32'(bus.byte_ready_o), 32'd0);
            bus.byte_valid_i = 1'b0;
            check({vecs[i].name, "_hold"}, 32'(bus.cpu_hold_o), 32'(!vecs[i].exp_done));
            check({vecs[i].name, "_words"}, 32'(bus.words_loaded_o), 32'(vecs[i].exp_words));
            check({vecs[i].name, "_writes"}, 32'(total_writes - base), 32'(vecs[i].exp_writes));
        end

        // Abort after 6 DATA bytes, then a clean reload.
        begin
            int base;
            logic [31:0] w1;
            pulse_start();
            send_word(32'd3, 1, 1'b1, 1'b0, 0);
            send_word(prog[0], 1, 1'b1, 1'b1, 0);
            w1 = prog[1];
            send_byte(w1[31:24], 1, 1'b1);
            send_byte(w1[23:16], 1, 1'b1);
            reset = 1'b0;
            #1;
            check("abort_ready", 32'(bus.byte_ready_o), 32'd0);
            check("abort_write", 32'(bus.mem_write_o), 32'd0);
            check("abort_addr", bus.mem_address_o, 32'd0);
            check("abort_data", bus.mem_data_o, 32'd0);
            check("abort_hold", 32'(bus.cpu_hold_o), 32'd1);
            check("abort_done", 32'(bus.done_o), 32'd0);
            check("abort_words", 32'(bus.words_loaded_o), 32'd0);
            @(negedge clk);
            @(negedge clk);
            base = total_writes;
            reset = 1'b1;
            repeat (3) @(negedge clk);
            check("post_abort_writes", 32'(total_writes - base), 32'd0);
            base = total_writes;
            run_nominal(1, 1'b1);
            @(negedge clk);
            check("reload_done", 32'(bus.done_o), 32'd1);
            check("reload_hold", 32'(bus.cpu_hold_o), 32'd0);
            check("reload_words", 32'(bus.words_loaded_o), 32'd3);
            check("reload_writes", 32'(total_writes - base), 32'd3);
        end

        check("double_strobe", 32'(dbl_strobe), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
